// File: rtl/uart_tx_port.sv
// uart_tx_port: byte FIFO feeding an 8N1 UART transmitter with a pollable status byte
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after the data bits.
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-high reset
//   wr_en    one-cycle write strobe; wr_data is pushed when the FIFO is not full
//   wr_data  byte to transmit
//   clr_ovf  clears the sticky overflow flag
//   tx       registered serial output, idle high
//   status   {4'b0, overflow, busy, empty, full}
module uart_tx_port #(
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       clr_ovf,
    output logic       tx,
    output logic [7:0] status
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [NW-1:0] N_FULL = NW'(DEPTH);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] count;
    logic          ovf, full, empty, push, pop, last, tx_n;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    sh, sh_n;

    // full/empty come from pre-edge occupancy, so a write while full is dropped even if IDLE pops
    assign full   = count == N_FULL;
    assign empty  = count == '0;
    assign push   = wr_en && !full;
    assign last   = cnt == C_LAST;
    assign status = {4'b0, ovf, state != IDLE, empty, full};

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wr_data;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            sh     <= '0;
            tx     <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + NW'(push) - NW'(pop);
            ovf    <= (wr_en && full) || (ovf && !clr_ovf);
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            sh     <= sh_n;
            tx     <= tx_n;
        end

    always_comb begin
        state_n = state;
        cnt_n   = last ? '0 : cnt + CW'(1);
        idx_n   = idx;
        sh_n    = sh;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    sh_n    = mem[rd_ptr];
                    state_n = START;
                end
            end
            START: if (last) begin
                state_n = DATA;
                idx_n   = '0;
            end
            DATA: if (last) begin
                idx_n = idx + 3'd1;
`ifdef UART_TX_PARITY_EN
                if (idx == 3'd7) state_n = PARITY;
`else
                if (idx == 3'd7) state_n = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (last) state_n = STOP;
`endif
            STOP: if (last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // tx is driven from the next state so the line changes on the same edge as the state
`ifdef UART_TX_PARITY_EN
        tx_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[idx_n] : state_n == PARITY ? ^sh_n : 1'b1;
`else
        tx_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[idx_n] : 1'b1;
`endif
    end
endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: self-checking bench for uart_tx_port (frame-position reference model plus directed sequences)
module tb_uart_tx_port;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;

    logic       clk = 0, reset = 0, wr_en = 0, clr_ovf = 0;
    logic [7:0] wr_data = 0;
    logic       tx;
    logic [7:0] status;

    uart_tx_port #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .clr_ovf(clr_ovf), .tx(tx), .status(status)
    );

    always #5 clk = ~clk;

    int vecs = 0, miss = 0, frames = 0;
    bit prev_busy = 0;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        vecs++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %h want %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: a queue of bytes and the position within the current frame.
    logic [7:0] mq[$];
    logic [7:0] m_cur;
    bit         m_act, m_ovf, m_full;
    int         m_pos;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_act = 0;
            m_ovf = 0;
            m_pos = 0;
        end else begin
            m_full = mq.size() == DEPTH;
            if (wr_en && m_full) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            if (m_act) begin
                m_pos++;
                if (m_pos == FL) m_act = 0;
            end else if (mq.size() != 0) begin
                m_cur = mq.pop_front();
                m_act = 1;
                m_pos = 0;
            end
            if (wr_en && !m_full) mq.push_back(wr_data);
        end
    end

    function automatic logic model_tx();
        int k = m_pos / CPB;
        if (!m_act) return 1'b1;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_cur[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^m_cur;
`endif
        return 1'b1;
    endfunction

    always @(negedge clk) if (!reset) begin
        chk("model_tx", {7'b0, tx}, {7'b0, model_tx()});
        chk("model_status", status, {4'b0, m_ovf, m_act, mq.size() == 0, mq.size() == DEPTH});
        if (status[2] && !prev_busy) frames++;
        prev_busy = status[2];
    end

    task automatic cyc(input logic we, input logic [7:0] d, input logic co);
        wr_en   = we;
        wr_data = d;
        clr_ovf = co;
        @(posedge clk);
        @(negedge clk);
        wr_en   = 0;
        clr_ovf = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (status !== 8'h02 && n < 2000) begin
            cyc(0, 0, 0);
            n++;
        end
        chk("wait_idle", status, 8'h02);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [0:8] lv;
        logic       par;
    } vec_t;

    vec_t       tbl[6];
    logic       sv[0:89];
    logic [7:0] d1, d2;
    logic       e;

    initial begin
        tbl[0] = '{8'hA5, 9'b010100101, 1'b0};
        tbl[1] = '{8'h07, 9'b011100000, 1'b1};
        tbl[2] = '{8'h01, 9'b010000000, 1'b1};
        tbl[3] = '{8'h80, 9'b000000001, 1'b1};
        tbl[4] = '{8'hFF, 9'b011111111, 1'b0};
        tbl[5] = '{8'h3C, 9'b000111100, 1'b0};

        #1 reset = 1;
        #2;
        chk("reset_tx", {7'b0, tx}, 8'h01);
        chk("reset_status", status, 8'h02);
        repeat (2) @(negedge clk);
        reset = 0;
        cyc(0, 0, 0);
        chk("post_reset", status, 8'h02);

        // table-driven single frames
        for (int i = 0; i < 6; i++) begin
            wait_idle();
            cyc(1, tbl[i].data, 0);
            chk("tbl_accept", status, 8'h00);
            for (int c = 0; c < FL; c++) begin
                int k;
                cyc(0, 0, 0);
                k = c / CPB;
                e = k <= 8 ? tbl[i].lv[k] : (NB == 11 && k == 9) ? tbl[i].par : 1'b1;
                chk("tbl_bit", {7'b0, tx}, {7'b0, e});
                chk("tbl_busy", {7'b0, status[2]}, 8'h01);
            end
            cyc(0, 0, 0);
            chk("tbl_done", status, 8'h02);
        end

        // back-to-back 01 then 80
        wait_idle();
        d1 = 8'h01;
        d2 = 8'h80;
        cyc(1, d1, 0);
        cyc(1, d2, 0);
        sv[0] = tx;
        for (int c = 1; c < 90; c++) begin
            cyc(0, 0, 0);
            sv[c] = tx;
        end
        for (int k = 0; k < 8; k++) begin
            chk("b2b_f1", {7'b0, sv[4*(k+1)+2]}, {7'b0, d1[k]});
            chk("b2b_f2", {7'b0, sv[FL+1+4*(k+1)+2]}, {7'b0, d2[k]});
        end
        for (int c = FL - 4; c <= FL; c++) chk("b2b_stop", {7'b0, sv[c]}, 8'h01);
        chk("b2b_start2", {7'b0, sv[FL+1]}, 8'h00);

        // fill and overflow
        wait_idle();
        frames = 0;
        for (int i = 1; i <= 5; i++) cyc(1, 8'(i * 8'h11), 0);
        chk("ovf_full", status, 8'h05);
        cyc(1, 8'h66, 0);
        chk("ovf_set", status, 8'h0D);
        cyc(0, 0, 1);
        chk("ovf_clr", status, 8'h05);
        wait_idle();
        chk("ovf_frames", 8'(frames), 8'd5);

        // FIFO filled during STOP, write lands on the IDLE pop edge
        wait_idle();
        cyc(1, 8'h3C, 0);
        for (int c = 0; c < FL - 4; c++) cyc(0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'hC0 + i), 0);
        chk("sim_full", status, 8'h05);
        cyc(0, 0, 0);
        chk("sim_idle", status, 8'h01);
        cyc(1, 8'hEE, 0);
        chk("sim_drop", status, 8'h0C);
        chk("sim_start", {7'b0, tx}, 8'h00);
        cyc(0, 0, 1);
        chk("sim_clr", status, 8'h04);
        wait_idle();

        // reset mid-frame
        cyc(1, 8'h5A, 0);
        repeat (15) cyc(0, 0, 0);
        #2 reset = 1;
        #1;
        chk("mid_reset_tx", {7'b0, tx}, 8'h01);
        chk("mid_reset_status", status, 8'h02);
        @(negedge clk);
        reset = 0;
        repeat (50) cyc(0, 0, 0);
        chk("after_reset", status, 8'h02);
        chk("after_reset_tx", {7'b0, tx}, 8'h01);

        // randomized traffic checked by the model
        for (int b = 0; b < 15; b++) begin
            int rate = $urandom_range(0, 1) ? 40 : 3;
            for (int c = 0; c < 200; c++)
                cyc($urandom_range(0, 99) < rate, 8'($urandom_range(0, 255)), $urandom_range(0, 63) == 0);
        end
        cyc(0, 0, 1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
